pipe_adder: RTL and testbench

PIPE_ADDER -- requirements
Module: pipe_adder

---
 rtl/pipe_adder.sv | 99 +++++++++
 tb/tb_pipe_adder.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/pipe_adder.sv
// Pipelined add/subtract unit: each stage ripples one CHUNK-bit slice, with skew registers for
// operands still to be consumed and deskew registers for sum slices already produced.
module pipe_adder #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned CHUNK = WIDTH / STAGES;

    logic [STAGES-1:0][WIDTH-1:0] a_q, a_d;
    logic [STAGES-1:0][WIDTH-1:0] b_q, b_d;
    logic [STAGES-1:0][WIDTH-1:0] s_q, s_d;
    logic [STAGES-1:0]            c_q, c_d;
    logic [STAGES-1:0]            vld_q, vld_d;

    // Per-stage inputs: stage 0 takes the port operands, stage k the registers of stage k-1.
    logic [STAGES-1:0][WIDTH-1:0] a_src, b_src, s_src;
    logic [STAGES-1:0]            c_src, vld_src;
    logic [CHUNK:0]               chunk_sum;
    logic                         adv;

    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;

    always_comb begin
        a_src    = a_q;
        b_src    = b_q;
        s_src    = s_q;
        c_src    = c_q;
        vld_src  = vld_q;
        // Subtraction is a + ~b + ~cin, so invert B and the carry before the first stage.
        a_src[0]   = a;
        b_src[0]   = sub ? ~b : b;
        s_src[0]   = '0;
        c_src[0]   = sub ? ~cin : cin;
        vld_src[0] = in_valid;
        for (int k = 1; k < STAGES; k++) begin
            a_src[k]   = a_q[k-1];
            b_src[k]   = b_q[k-1];
            s_src[k]   = s_q[k-1];
            c_src[k]   = c_q[k-1];
            vld_src[k] = vld_q[k-1];
        end
    end

    always_comb begin
        a_d       = a_src;
        b_d       = b_src;
        s_d       = s_src;
        c_d       = c_src;
        vld_d     = vld_src;
        chunk_sum = '0;
        for (int k = 0; k < STAGES; k++) begin
            chunk_sum = {1'b0, a_src[k][k*CHUNK +: CHUNK]}
                      + {1'b0, b_src[k][k*CHUNK +: CHUNK]}
                      + {{CHUNK{1'b0}}, c_src[k]};
            s_d[k][k*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
            c_d[k]                   = chunk_sum[CHUNK];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q   <= '0;
            b_q   <= '0;
            s_q   <= '0;
            c_q   <= '0;
            vld_q <= '0;
        end else if (adv) begin
            a_q   <= a_d;
            b_q   <= b_d;
            s_q   <= s_d;
            c_q   <= c_d;
            vld_q <= vld_d;
        end
    end

    assign out_valid = vld_q[STAGES-1];
    assign s         = s_q[STAGES-1];
    assign cout      = c_q[STAGES-1];
    // Carry into the MSB is recovered from the MSB sum bit and the effective operands.
    assign ovf       = a_q[STAGES-1][WIDTH-1] ^ b_q[STAGES-1][WIDTH-1]
                     ^ s_q[STAGES-1][WIDTH-1] ^ c_q[STAGES-1];

endmodule

// File: tb/tb_pipe_adder.sv
// Bench for pipe_adder: directed 8-bit/2-stage vectors, backpressure and reset cases, plus an
// exhaustive 4-bit/1-stage sweep against an integer arithmetic model.
module tb_pipe_adder;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
    logic [7:0] a, b, s;

    logic       in_valid4, in_ready4, cin4, sub4, out_valid4, out_ready4, cout4, ovf4;
    logic [3:0] a4, b4, s4;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pipe_adder #(.WIDTH(8), .STAGES(2)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready), .s(s),
        .cout(cout), .ovf(ovf)
    );

    pipe_adder #(.WIDTH(4), .STAGES(1)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4), .a(a4), .b(b4),
        .cin(cin4), .sub(sub4), .out_valid(out_valid4), .out_ready(out_ready4), .s(s4),
        .cout(cout4), .ovf(ovf4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Integer model: unsigned result with carry, and signed range test for overflow.
    task automatic model(input int w, input int av, input int bv, input int ci, input int sb,
                         output int es, output int ec, output int eo);
        int mask, t, sa, sbv, sr;
        mask = (1 << w) - 1;
        t    = sb ? av + ((~bv) & mask) + (1 - ci) : av + bv + ci;
        es   = t & mask;
        ec   = (t >> w) & 1;
        sa   = (av >= (1 << (w - 1))) ? av - (1 << w) : av;
        sbv  = (bv >= (1 << (w - 1))) ? bv - (1 << w) : bv;
        sr   = sb ? sa - sbv - ci : sa + sbv + ci;
        eo   = (sr > (1 << (w - 1)) - 1 || sr < -(1 << (w - 1))) ? 1 : 0;
    endtask

    // One 8-bit transaction with out_ready=1; result expected two edges after acceptance.
    task automatic single8(input string tag, input logic [7:0] av, input logic [7:0] bv,
                           input logic ci, input logic sb, input logic [7:0] es,
                           input logic ec, input logic eo);
        a = av; b = bv; cin = ci; sub = sb; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check({tag, "_lat1"}, {31'd0, out_valid}, 32'd0);
        step();
        check({tag, "_res"}, {22'd0, out_valid, ovf, cout, s}, {22'd0, 1'b1, eo, ec, es});
        step();
        check({tag, "_drain"}, {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        int es, ec, eo;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; cin = 0; sub = 0;
        in_valid4 = 1'b0; out_ready4 = 1'b1; a4 = '0; b4 = '0; cin4 = 0; sub4 = 0;
        repeat (3) step();
        rst = 1'b0;
        #1;
        check("reset_state", {20'd0, in_ready, out_valid, ovf, cout, s},
              {20'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00});

        single8("wrap",     8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        single8("sovf",     8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
        single8("borrow",   8'h10, 8'h20, 1'b0, 1'b1, 8'hF0, 1'b0, 1'b0);
        single8("borrowin", 8'h05, 8'h03, 1'b1, 1'b1, 8'h01, 1'b1, 1'b0);
        single8("negovf",   8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);

        // Backpressure: two accepted while the output is empty, the third waits on in_ready.
        out_ready = 1'b0; cin = 0; sub = 0;
        in_valid = 1'b1; a = 8'h01; b = 8'h01;
        step();
        a = 8'h02; b = 8'h02;
        step();
        a = 8'h03; b = 8'h03;
        check("bp_first", {22'd0, out_valid, in_ready, s}, {22'd0, 1'b1, 1'b0, 8'h02});
        for (int i = 0; i < 4; i++) begin
            step();
            check("bp_stall", {22'd0, out_valid, in_ready, s}, {22'd0, 1'b1, 1'b0, 8'h02});
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", {31'd0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        check("bp_res2", {23'd0, out_valid, s}, {23'd0, 1'b1, 8'h04});
        step();
        check("bp_res3", {23'd0, out_valid, s}, {23'd0, 1'b1, 8'h06});
        step();
        check("bp_empty", {31'd0, out_valid}, 32'd0);

        // Reset with two transactions in flight and a third presented during reset.
        out_ready = 1'b0; in_valid = 1'b1; a = 8'h11; b = 8'h22;
        step();
        a = 8'h33; b = 8'h44;
        step();
        check("rst_pre_full", {31'd0, out_valid}, 32'd1);
        rst = 1'b1; a = 8'h55; b = 8'h66;
        step();
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        #1;
        check("rst_clear", {20'd0, in_ready, out_valid, ovf, cout, s},
              {20'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00});
        for (int i = 0; i < 4; i++) begin
            step();
            check("rst_no_stale", {31'd0, out_valid}, 32'd0);
        end

        // Exhaustive 4-bit sweep, one result per cycle through the single-stage instance.
        in_valid4 = 1'b1;
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < 512; i++) begin
                logic [8:0] v;
                v = 9'(i);
                {b4, a4, cin4} = v;
                sub4 = m[0];
                model(4, int'(a4), int'(b4), int'(cin4), m, es, ec, eo);
                step();
                check(m ? "sweep_sub" : "sweep_add", {25'd0, out_valid4, ovf4, cout4, s4},
                      {25'd0, 1'b1, eo[0], ec[0], es[3:0]});
            end
        end
        in_valid4 = 1'b0;
        step();
        check("sweep_drain", {31'd0, out_valid4}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
